// File: rtl/weight_tile_pkg.sv
// weight_tile_pkg: FSM states and default geometry shared by the
// tile address generators.
package weight_tile_pkg;

    localparam int TILE_DEF   = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int DIM_W_DEF  = 12;
    localparam int REP_W_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tile_state_e;

endpackage

// File: rtl/tile_nest_counter.sv
// tile_nest_counter: cascaded wrap counters, level 0 innermost, with
// look-ahead next values and per-level step/wrap flags.
module tile_nest_counter #(
    parameter int N = 5,
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                adv,
    input  logic [N-1:0][W-1:0] term,
    output logic [N-1:0][W-1:0] cnt_d,
    output logic [N-1:0]        step,
    output logic [N-1:0]        wrap,
    output logic                all_term
);

    logic [N-1:0][W-1:0] cnt_q;
    logic                carry;
    logic                at;

    always_comb begin
        cnt_d    = cnt_q;
        step     = '0;
        wrap     = '0;
        all_term = 1'b1;
        carry    = adv;
        at       = 1'b0;
        for (int i = 0; i < N; i++) begin
            at       = (cnt_q[i] == term[i]);
            all_term = all_term & at;
            step[i]  = carry;
            wrap[i]  = carry & at;
            if (carry)
                cnt_d[i] = at ? '0 : cnt_q[i] + W'(1);
            carry = carry & at;
        end
        if (clr)
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/weight_tile_addr_gen.sv
// weight_tile_addr_gen: tiled weight-buffer address walker with pad flags.
// WEIGHT_TILE_TRANSPOSE_EN enables column-major intra-tile order.
module weight_tile_addr_gen
    import weight_tile_pkg::*;
#(
    parameter int TILE   = TILE_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DIM_W-1:0]  cfg_stride,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic              cfg_transpose,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pad,
    output logic              o_valid,
    output logic              o_tile_last,
    output logic              o_done,
    output logic              o_busy
);

    localparam int LT = $clog2(TILE);
    localparam int CW = (DIM_W > REP_W) ? DIM_W : REP_W;
    localparam int PW = DIM_W + 1;

    tile_state_e state_q, state_d;
    logic clr, adv, ld, zero_cfg, tp;

    logic [DIM_W-1:0]  rows_q, cols_q, stride_q;
    logic [REP_W-1:0]  rep_q;
    logic [ADDR_W-1:0] tr_org_q, tile_org_q, rs_q;
    logic [ADDR_W-1:0] tr_org_d, tile_org_d, rs_d;
    logic [ADDR_W-1:0] stride_a, addr_d;

    logic [4:0][CW-1:0] term, cnt_d;
    logic [4:0]         step, wrap;
    logic               all_term;

    logic [LT-1:0]    c_d, r_d;
    logic             step_r, wrap_r, pad_d, last_d;
    logic [PW-1:0]    row_d, col_d;
    logic [DIM_W-1:0] rows_e, cols_e;

    assign zero_cfg = (cfg_rows == '0) || (cfg_cols == '0) ||
                      (cfg_repeat == '0);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        adv     = 1'b0;
        ld      = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = zero_cfg ? DONE : RUN;
                clr     = !zero_cfg;
                ld      = !zero_cfg;
            end
            RUN: if (i_ready) begin
                if (all_term) begin
                    state_d = DONE;
                end else begin
                    adv = 1'b1;
                    ld  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign o_valid = (state_q == RUN);
    assign o_done  = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);

`ifdef WEIGHT_TILE_TRANSPOSE_EN
    logic tp_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tp_q <= 1'b0;
        else if (clr)
            tp_q <= cfg_transpose;
    end
    assign tp = tp_q;
`else
    assign tp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_q   <= '0;
            cols_q   <= '0;
            stride_q <= '0;
            rep_q    <= '0;
        end else if (clr) begin
            rows_q   <= cfg_rows;
            cols_q   <= cfg_cols;
            stride_q <= cfg_stride;
            rep_q    <= cfg_repeat;
        end
    end

    // levels: inner, outer (c/r swapped by tp), tc, rep, tr
    assign term[0] = CW'(TILE - 1);
    assign term[1] = CW'(TILE - 1);
    assign term[2] = CW'((cols_q - DIM_W'(1)) >> LT);
    assign term[3] = CW'(rep_q - REP_W'(1));
    assign term[4] = CW'((rows_q - DIM_W'(1)) >> LT);

    tile_nest_counter #(.N(5), .W(CW)) u_nest (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .adv      (adv),
        .term     (term),
        .cnt_d    (cnt_d),
        .step     (step),
        .wrap     (wrap),
        .all_term (all_term)
    );

    assign c_d    = tp ? cnt_d[1][LT-1:0] : cnt_d[0][LT-1:0];
    assign r_d    = tp ? cnt_d[0][LT-1:0] : cnt_d[1][LT-1:0];
    assign step_r = tp ? step[0] : step[1];
    assign wrap_r = tp ? wrap[0] : wrap[1];

    assign stride_a = ADDR_W'(stride_q);

    // tile-row origin is kept so each replay restarts from it
    always_comb begin
        tr_org_d   = tr_org_q;
        tile_org_d = tile_org_q;
        rs_d       = rs_q;
        if (clr) begin
            tr_org_d   = cfg_base;
            tile_org_d = cfg_base;
            rs_d       = '0;
        end else if (adv) begin
            if (step_r)
                rs_d = wrap_r ? '0 : rs_q + stride_a;
            if (step[2]) begin
                if (!wrap[2]) begin
                    tile_org_d = tile_org_q + ADDR_W'(TILE);
                end else if (wrap[3]) begin
                    tr_org_d   = tr_org_q + (stride_a << LT);
                    tile_org_d = tr_org_d;
                end else begin
                    tile_org_d = tr_org_q;
                end
            end
        end
    end

    assign rows_e = clr ? cfg_rows : rows_q;
    assign cols_e = clr ? cfg_cols : cols_q;
    assign row_d  = (PW'(cnt_d[4]) << LT) + PW'(r_d);
    assign col_d  = (PW'(cnt_d[2]) << LT) + PW'(c_d);
    assign pad_d  = (row_d >= {1'b0, rows_e}) ||
                    (col_d >= {1'b0, cols_e});
    assign last_d = (cnt_d[0][LT-1:0] == LT'(TILE - 1)) &&
                    (cnt_d[1][LT-1:0] == LT'(TILE - 1));
    assign addr_d = tile_org_d + rs_d + ADDR_W'(c_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tr_org_q    <= '0;
            tile_org_q  <= '0;
            rs_q        <= '0;
            o_addr      <= '0;
            o_pad       <= 1'b0;
            o_tile_last <= 1'b0;
        end else begin
            tr_org_q   <= tr_org_d;
            tile_org_q <= tile_org_d;
            rs_q       <= rs_d;
            if (ld) begin
                o_addr      <= pad_d ? '0 : addr_d;
                o_pad       <= pad_d;
                o_tile_last <= last_d;
            end
        end
    end

    logic unused_sig;
    assign unused_sig = ^{cfg_transpose, cnt_d[3],
                          cnt_d[1][CW-1:LT], cnt_d[0][CW-1:LT],
                          step[4:3], wrap[4]};

endmodule

// File: tb/tb_weight_tile_addr_gen.sv
// tb_weight_tile_addr_gen: directed checks of tiled address walk,
// padding, replay, stalls, framing and reset abort.
module tb_weight_tile_addr_gen;

`ifdef WEIGHT_TILE_TRANSPOSE_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn, start, cfg_transpose, i_ready;
    logic [15:0] cfg_base;
    logic [11:0] cfg_rows, cfg_cols, cfg_stride;
    logic [9:0]  cfg_repeat;
    logic [15:0] o_addr;
    logic        o_pad, o_valid, o_tile_last, o_done, o_busy;

    int npass = 0;
    int ntot  = 0;

    logic [15:0] got_a[$];
    logic        got_p[$];
    logic        got_l[$];
    logic [15:0] ref_a[$];

    always #5 clk = ~clk;

    weight_tile_addr_gen dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .cfg_base      (cfg_base),
        .cfg_rows      (cfg_rows),
        .cfg_cols      (cfg_cols),
        .cfg_stride    (cfg_stride),
        .cfg_repeat    (cfg_repeat),
        .cfg_transpose (cfg_transpose),
        .i_ready       (i_ready),
        .o_addr        (o_addr),
        .o_pad         (o_pad),
        .o_valid       (o_valid),
        .o_tile_last   (o_tile_last),
        .o_done        (o_done),
        .o_busy        (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model(input int k, input int base,
                                  input int rows, input int cols,
                                  input int stride, input int rep,
                                  input bit tp, output logic [15:0] a,
                                  output logic p, output logic l);
        int ntc, w, t, r, c, tc, tr, row, col;
        ntc = (cols + 7) / 8;
        w   = k % 64;
        t   = k / 64;
        r   = tp ? w % 8 : w / 8;
        c   = tp ? w / 8 : w % 8;
        tc  = t % ntc;
        tr  = t / (ntc * rep);
        row = tr * 8 + r;
        col = tc * 8 + c;
        p   = (row >= rows) || (col >= cols);
        a   = p ? 16'h0 : 16'(base + row * stride + col);
        l   = (w == 63);
    endfunction

    task automatic run_job(input string tag, input int base,
                           input int rows, input int cols,
                           input int stride, input int rep,
                           input bit tp, input bit rnd,
                           input int glitch_at, input int exp_n);
        int          n, stall_err, seq_err;
        bit          stall, fin, gdone;
        logic [15:0] pa, ea;
        logic        pp, pl, ep, el, rdy;
        n = 0; stall_err = 0; seq_err = 0;
        stall = 0; fin = 0; gdone = 0;
        pa = '0; pp = 0; pl = 0;
        got_a.delete(); got_p.delete(); got_l.delete();
        @(negedge clk);
        cfg_base = 16'(base); cfg_rows = 12'(rows);
        cfg_cols = 12'(cols); cfg_stride = 12'(stride);
        cfg_repeat = 10'(rep); cfg_transpose = tp;
        i_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_first_valid"}, o_valid, 1);
        chk({tag, "_first_busy"}, o_busy, 1);
        for (int cyc = 0; cyc < exp_n * 4 + 40 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start    = 1'b0;
            cfg_rows = 12'(rows);
            if (glitch_at > 0 && n == glitch_at && !gdone) begin
                start    = 1'b1;
                cfg_rows = 12'(rows + 8);
                gdone    = 1;
            end
            if (stall && (o_addr !== pa || o_pad !== pp ||
                          o_tile_last !== pl || o_valid !== 1'b1))
                stall_err++;
            stall = 0;
            if (o_valid) begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_ready = rdy;
                if (rdy) begin
                    got_a.push_back(o_addr);
                    got_p.push_back(o_pad);
                    got_l.push_back(o_tile_last);
                    n++;
                    if (n == exp_n) fin = 1;
                end else begin
                    stall = 1;
                    pa = o_addr; pp = o_pad; pl = o_tile_last;
                end
            end else begin
                i_ready = 1'b1;
                fin = 1;
            end
        end
        start = 1'b0;
        chk({tag, "_beats"}, n, exp_n);
        chk({tag, "_stall"}, stall_err, 0);
        @(negedge clk);
        i_ready = 1'b1;
        chk({tag, "_done_valid"}, o_valid, 0);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_done_busy"}, o_busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_busy"}, o_busy, 0);
        chk({tag, "_idle_done"}, o_done, 0);
        @(negedge clk);
        chk({tag, "_start_on_done"}, {o_valid, o_busy}, 0);
        for (int k = 0; k < n; k++) begin
            model(k, base, rows, cols, stride, rep, tp & TP_EN,
                  ea, ep, el);
            if (got_a[k] !== ea || got_p[k] !== ep || got_l[k] !== el)
                seq_err++;
        end
        chk({tag, "_seq"}, seq_err, 0);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0; start = 1'b0; i_ready = 1'b1;
        cfg_base = '0; cfg_rows = '0; cfg_cols = '0;
        cfg_stride = '0; cfg_repeat = '0; cfg_transpose = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {o_valid, o_busy, o_done, o_pad,
                         o_tile_last, o_addr}, 0);
        rstn = 1'b1;
        @(negedge clk);

        run_job("t1", 0, 16, 16, 16, 1, 0, 0, 0, 256);
        chk("t1_b0", got_a[0], 16'd0);
        chk("t1_b8", got_a[8], 16'd16);
        chk("t1_b64", got_a[64], 16'd8);
        chk("t1_b128", got_a[128], 16'd128);
        chk("t1_last63", got_l[63], 1);
        cnt = 0;
        foreach (got_p[k]) if (got_p[k]) cnt++;
        chk("t1_nopad", cnt, 0);

        run_job("t2", 0, 10, 12, 12, 1, 0, 0, 0, 256);
        chk("t2_b67", got_a[67], 16'd11);
        chk("t2_b68_pad", got_p[68], 1);
        chk("t2_b68_addr", got_a[68], 16'd0);
        chk("t2_b136", got_a[136], 16'd108);
        cnt = 0;
        for (int k = 128; k < 256; k++)
            if ((k % 64) / 8 >= 2 && got_p[k] !== 1'b1) cnt++;
        chk("t2_rt1_pad", cnt, 0);

        run_job("t3", 'h100, 8, 8, 8, 3, 0, 0, 0, 192);
        chk("t3_b0", got_a[0], 16'h100);
        chk("t3_b64", got_a[64], 16'h100);
        chk("t3_b128", got_a[128], 16'h100);
        chk("t3_b63", got_a[63], 16'h13F);
        ref_a = got_a;

        run_job("t4", 'h100, 8, 8, 8, 3, 0, 1, 0, 192);
        cnt = 0;
        foreach (ref_a[k]) if (got_a[k] !== ref_a[k]) cnt++;
        chk("t4_same_seq", cnt, 0);

        @(negedge clk);
        cfg_cols = '0; cfg_rows = 12'd8; cfg_repeat = 10'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zc_done", o_done, 1);
        chk("zc_valid", o_valid, 0);
        chk("zc_busy", o_busy, 1);
        @(negedge clk);
        chk("zc_idle", {o_valid, o_busy, o_done}, 0);

        run_job("t5", 'h40, 8, 8, 8, 1, 0, 0, 10, 64);

        @(negedge clk);
        cfg_base = '0; cfg_rows = 12'd16; cfg_cols = 12'd16;
        cfg_stride = 12'd16; cfg_repeat = 10'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_pre_valid", o_valid, 1);
        rstn = 1'b0;
        #1;
        chk("abort_outs", {o_valid, o_busy, o_done, o_pad,
                           o_tile_last, o_addr}, 0);
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid || o_done || o_busy) cnt++;
        end
        chk("abort_quiet", cnt, 0);

        run_job("t6", 0, 8, 8, 8, 1, 1, 0, 0, 64);
        if (TP_EN) begin
            chk("t6_b1", got_a[1], 16'd8);
            chk("t6_b8", got_a[8], 16'd1);
        end else begin
            chk("t6_b1", got_a[1], 16'd1);
            chk("t6_b8", got_a[8], 16'd8);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
